// File: rtl/dmem_responder_pkg.sv
// Shared types and widths for the data-memory responder.
// Fault checking is enabled with the DMEM_ERR_EN macro.
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM with byte write enables.
// Writes are synchronous; reads are combinational.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [NBYTES-1:0]              be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata
);

  logic [WORD_W-1:0] ram_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (be[i]) begin
          ram_q[idx][i*BYTE_W +: BYTE_W] <=
            wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rdata = ram_q[idx];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with programmable wait states.
// Define DMEM_ERR_EN to report misaligned / out-of-range accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT =
    CNT_W'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   be_q, be_d;
  logic                fault_q, fault_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                ram_we;
  logic [WORD_W-1:0]   ram_rdata;
  logic                req_fault;

`ifdef DMEM_ERR_EN
  assign req_fault =
    (req_addr[1:0] != 2'b00) ||
    (req_addr[WORD_W-1:AW+2] != '0);
`else
  logic unused_addr;
  assign req_fault   = 1'b0;
  assign unused_addr =
    ^{req_addr[WORD_W-1:AW+2], req_addr[1:0]};
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .be    (be_q),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[AW+1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          fault_d = req_fault;
          cnt_d   = WAIT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          // Access happens exactly once, on the last wait cycle.
          ram_we  = we_q && !fault_q;
          rdata_d = (we_q || fault_q) ? '0 : ram_rdata;
          err_d   = fault_q;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: transaction-level memory model plus
// directed vectors; a second instance covers zero wait states.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        z_valid = 1'b0;
  logic        z_ready;
  logic        z_we = 1'b0;
  logic [31:0] z_addr = '0;
  logic [31:0] z_wdata = '0;
  logic [3:0]  z_be = '0;
  logic        z_rvalid;
  logic        z_rready = 1'b0;
  logic [31:0] z_rdata;
  logic        z_err;

  int n_checks = 0;
  int n_errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_valid), .req_ready(z_ready),
    .req_we(z_we), .req_addr(z_addr),
    .req_wdata(z_wdata), .req_be(z_be),
    .rsp_valid(z_rvalid), .rsp_ready(z_rready),
    .rsp_rdata(z_rdata), .rsp_err(z_err)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: a word array plus a countdown to the response.
  logic [31:0] mm [DEPTH];
  bit          m_busy, m_resp, m_err, m_we;
  int          m_left;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  function automatic bit m_fault(input logic [31:0] a);
`ifdef DMEM_ERR_EN
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
`else
    return (a == 32'hFFFF_FFFF) && (a != a);
`endif
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy  <= 1'b1;
        m_left  <= WAITC + 1;
        m_we    <= req_we;
        m_addr  <= req_addr;
        m_wdata <= req_wdata;
        m_be    <= req_be;
      end
    end else if (!m_resp) begin
      if (m_left == 1) begin
        m_resp <= 1'b1;
        m_err  <= m_fault(m_addr);
        if (m_we) begin
          m_rdata <= 32'h0;
          if (!m_fault(m_addr))
            for (int i = 0; i < 4; i++)
              if (m_be[i])
                mm[m_idx(m_addr)][8*i +: 8] <= m_wdata[8*i +: 8];
        end else begin
          m_rdata <= m_fault(m_addr) ? 32'h0 : mm[m_idx(m_addr)];
        end
      end
      m_left <= m_left - 1;
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
      m_resp <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      if (m_resp) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b,
                     input int hold, output int lat,
                     output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a;
    req_wdata = wd; req_be = b; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: got no rsp_valid expected one");
    end
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rdata", rsp_rdata, rd);
      check("hold_req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic txn0(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, output int lat,
                      output logic [31:0] rd, output logic er);
    @(negedge clk);
    z_valid = 1'b1; z_we = we; z_addr = a;
    z_wdata = wd; z_be = 4'hF; z_rready = 1'b0;
    @(negedge clk);
    z_valid = 1'b0;
    lat = 0;
    while (!z_rvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = z_rdata;
    er = z_err;
    z_rready = 1'b1;
    @(negedge clk);
    z_rready = 1'b0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b1;
    run = 1'b1;

    txn(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, lat, rd, er);
    check("st_latency", lat, 3);
    check("st_rdata", rd, 32'h0);
    txn(0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er);
    check("ld_latency", lat, 3);
    check("ld_full", rd, 32'hDEAD_BEEF);

    txn(1, 32'h10, 32'h0000_AA00, 4'b0010, 0, lat, rd, er);
    txn(0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er);
    check("ld_partial", rd, 32'hDEAD_AAEF);

    txn(1, 32'h10, 32'h1234_5678, 4'b0000, 0, lat, rd, er);
    txn(0, 32'h10, 32'h0, 4'h0, 5, lat, rd, er);
    check("ld_be0_backpressure", rd, 32'hDEAD_AAEF);

    txn(1, 32'hFFC, 32'hA5A5_0001, 4'hF, 0, lat, rd, er);
    txn(0, 32'hFFC, 32'h0, 4'h0, 0, lat, rd, er);
    check("ld_top_word", rd, 32'hA5A5_0001);

    txn(1, 32'h0, 32'hCAFE_0000, 4'hF, 0, lat, rd, er);
    txn(1, 32'h1000, 32'h0000_0011, 4'hF, 0, lat, rd, er);
`ifdef DMEM_ERR_EN
    check("wrap_st_err", 32'(er), 32'h1);
`else
    check("wrap_st_err", 32'(er), 32'h0);
`endif
    txn(0, 32'h0, 32'h0, 4'h0, 0, lat, rd, er);
`ifdef DMEM_ERR_EN
    check("wrap_ld", rd, 32'hCAFE_0000);
`else
    check("wrap_ld", rd, 32'h0000_0011);
`endif
    txn(0, 32'h12, 32'h0, 4'h0, 0, lat, rd, er);
`ifdef DMEM_ERR_EN
    check("misalign_ld", rd, 32'h0);
    check("misalign_err", 32'(er), 32'h1);
`else
    check("misalign_ld", rd, 32'hDEAD_AAEF);
    check("misalign_err", 32'(er), 32'h0);
`endif

    txn(1, 32'h20, 32'h1234_5678, 4'hF, 0, lat, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_req_ready", 32'(req_ready), 32'h1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (4) @(negedge clk);
    check("midrst_quiet", 32'(rsp_valid), 32'h0);
    txn(0, 32'h20, 32'h0, 4'h0, 0, lat, rd, er);
    check("midrst_ram", rd, 32'h1234_5678);

    txn0(1, 32'h40, 32'h5A5A_5A5A, lat, rd, er);
    check("w0_st_latency", lat, 1);
    txn0(0, 32'h40, 32'h0, lat, rd, er);
    check("w0_ld_latency", lat, 1);
    check("w0_ld_rdata", rd, 32'h5A5A_5A5A);
    check("w0_ld_err", 32'(er), 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
